board_line_clear: RTL and testbench

- Writer-side engine for the 20x10 Tetris board RAM that the VGA scan reads.
- On a start pulse it scans the board bottom-up and detects full rows. For each full row it shifts every row above down by one and clears row 0, then reports how many lines were removed.
- It shares the RAM port with the CPU. It drives the port only in cycles where the CPU is not doing LW/SW.

---
 rtl/tetris_board_pkg.sv | 37 +++
 rtl/board_addr_gen.sv | 34 +++
 rtl/board_line_clear.sv | 228 ++++++++++++++++++++++
 tb/tb_board_line_clear.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tetris_board_pkg.sv
// Shared board definitions for the Tetris board RAM writers and the VGA reader.
// Contents: board dimensions, empty-cell code, colour codes, line-clear FSM states,
// and a cell occupancy helper.
package tetris_board_pkg;

    localparam int unsigned ROWS = 20;
    localparam int unsigned COLS = 10;

    localparam logic [2:0] EMPTY_CELL = 3'b000;

    typedef enum logic [2:0] {
        COLOR_NONE   = 3'd0,
        COLOR_CYAN   = 3'd1,
        COLOR_YELLOW = 3'd2,
        COLOR_GREEN  = 3'd3,
        COLOR_RED    = 3'd4,
        COLOR_PURPLE = 3'd5,
        COLOR_ORANGE = 3'd6,
        COLOR_BLUE   = 3'd7
    } color_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN_RD,
        ST_SCAN_CHK,
        ST_COPY_RD,
        ST_COPY_WR,
        ST_CLR_WR,
        ST_DONE
    } lc_state_e;

    // Only the colour field decides occupancy; upper bits are payload.
    function automatic logic cell_occupied(input logic [31:0] word);
        return word[2:0] != EMPTY_CELL;
    endfunction

endpackage

// File: rtl/board_addr_gen.sv
// Board cell address generator: addr_c = BASE_ADDR + COLS*row + col.
// The row product is built from shifted copies of row, one per set bit of COLS
// (for COLS=10: (row<<3) + (row<<1)), so no multiplier is inferred.
// Ports:
//   row    - cell row index
//   col    - cell column index
//   addr_c - combinational RAM word address
module board_addr_gen
    import tetris_board_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned COLS       = tetris_board_pkg::COLS,
    parameter int unsigned ROW_W      = 5,
    parameter int unsigned COL_W      = 4
) (
    input  logic [ROW_W-1:0]      row,
    input  logic [COL_W-1:0]      col,
    output logic [ADDR_WIDTH-1:0] addr_c
);

    localparam logic [31:0] COLS_BITS = 32'(COLS);

    // Constant multiply as a shift-add chain.
    always_comb begin
        addr_c = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(col);
        for (int i = 0; i < 32; i++) begin
            if (COLS_BITS[i]) begin
                addr_c = addr_c + (ADDR_WIDTH'(row) << i);
            end
        end
    end

endmodule

// File: rtl/board_line_clear.sv
// Line-clear engine for the Tetris board RAM. On start it scans rows bottom-up,
// and for every full row shifts all rows above down by one, clears row 0 and
// rescans the same row index. Reports the number of removed rows.
// The RAM port is shared with the CPU; an access happens only when
// mem_req=1 and mem_grant=1, otherwise the request is held unchanged.
// Ports:
//   clock, reset        - clock, asynchronous active-low reset
//   start               - pulse to begin a pass (ignored while busy)
//   busy, done          - pass in progress / one-cycle completion pulse
//   lines_cleared       - rows removed by the last pass
//   mem_grant           - RAM port free this cycle
//   mem_req, mem_we     - access request / write enable
//   mem_addr, mem_wdata - access address / write data
//   mem_rdata           - read data, valid one cycle after a granted read
module board_line_clear
    import tetris_board_pkg::*;
#(
    parameter int unsigned ROWS       = tetris_board_pkg::ROWS,
    parameter int unsigned COLS       = tetris_board_pkg::COLS,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [4:0]            lines_cleared,
    input  logic                  mem_grant,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata
);

    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(COLS - 1);
    localparam logic [4:0]       LINES_MAX = 5'(ROWS);

    lc_state_e        state, state_n;
    logic [ROW_W-1:0] row, row_n;
    logic [ROW_W-1:0] dst, dst_n;
    logic [COL_W-1:0] col, col_n;
    logic             have_data, have_data_n;
    logic             busy_n, done_n, req_n, we_n;
    logic [4:0]       lines_n;
    logic [31:0]      wdata_n;
    logic             granted;
    logic [ROW_W-1:0] arow;
    logic [COL_W-1:0] acol;
    logic [ADDR_WIDTH-1:0] addr_c;

    board_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR),
        .COLS       (COLS),
        .ROW_W      (ROW_W),
        .COL_W      (COL_W)
    ) u_addr_gen (
        .row    (arow),
        .col    (acol),
        .addr_c (addr_c)
    );

    assign granted = mem_req && mem_grant;

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            row           <= '0;
            dst           <= '0;
            col           <= '0;
            have_data     <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            lines_cleared <= '0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
        end else begin
            state         <= state_n;
            row           <= row_n;
            dst           <= dst_n;
            col           <= col_n;
            have_data     <= have_data_n;
            busy          <= busy_n;
            done          <= done_n;
            lines_cleared <= lines_n;
            mem_req       <= req_n;
            mem_we        <= we_n;
            mem_addr      <= addr_c;
            mem_wdata     <= wdata_n;
        end
    end

    // Next state, then the RAM command for the state being entered.
    always_comb begin
        state_n     = state;
        row_n       = row;
        dst_n       = dst;
        col_n       = col;
        have_data_n = have_data;
        busy_n      = busy;
        done_n      = 1'b0;
        lines_n     = lines_cleared;
        wdata_n     = mem_wdata;
        req_n       = 1'b0;
        we_n        = 1'b0;
        arow        = '0;
        acol        = '0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    row_n   = LAST_ROW;
                    col_n   = '0;
                    lines_n = '0;
                    busy_n  = 1'b1;
                    state_n = ST_SCAN_RD;
                end
            end
            ST_SCAN_RD: begin
                if (granted) begin
                    state_n = ST_SCAN_CHK;
                end
            end
            ST_SCAN_CHK: begin
                if (!cell_occupied(mem_rdata)) begin
                    if (row == '0) begin
                        state_n = ST_DONE;
                    end else begin
                        row_n   = row - ROW_W'(1);
                        col_n   = '0;
                        state_n = ST_SCAN_RD;
                    end
                end else if (col != LAST_COL) begin
                    col_n   = col + COL_W'(1);
                    state_n = ST_SCAN_RD;
                end else begin
                    lines_n = (lines_cleared >= LINES_MAX) ? lines_cleared
                                                           : lines_cleared + 5'd1;
                    dst_n   = row;
                    col_n   = '0;
                    state_n = ST_COPY_RD;
                end
            end
            ST_COPY_RD: begin
                if (dst == '0) begin
                    state_n = ST_CLR_WR;
                end else if (granted) begin
                    have_data_n = 1'b0;
                    state_n     = ST_COPY_WR;
                end
            end
            ST_COPY_WR: begin
                // First cycle captures the word read from the row above.
                if (!have_data) begin
                    wdata_n     = mem_rdata;
                    have_data_n = 1'b1;
                end else if (granted) begin
                    if (col != LAST_COL) begin
                        col_n = col + COL_W'(1);
                    end else begin
                        col_n = '0;
                        dst_n = dst - ROW_W'(1);
                    end
                    state_n = ST_COPY_RD;
                end
            end
            ST_CLR_WR: begin
                if (granted) begin
                    if (col != LAST_COL) begin
                        col_n = col + COL_W'(1);
                    end else begin
                        col_n   = '0;
                        state_n = ST_SCAN_RD;
                    end
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        case (state_n)
            ST_SCAN_RD: begin
                req_n = 1'b1;
                arow  = row_n;
                acol  = col_n;
            end
            ST_COPY_RD: begin
                req_n = (dst_n != '0);
                arow  = (dst_n != '0) ? dst_n - ROW_W'(1) : '0;
                acol  = col_n;
            end
            ST_COPY_WR: begin
                req_n = have_data_n;
                we_n  = have_data_n;
                arow  = dst_n;
                acol  = col_n;
            end
            ST_CLR_WR: begin
                req_n   = 1'b1;
                we_n    = 1'b1;
                arow    = '0;
                acol    = col_n;
                wdata_n = '0;
            end
            ST_DONE: begin
                done_n = 1'b1;
                busy_n = 1'b0;
            end
            default: begin
                arow = row_n;
                acol = col_n;
            end
        endcase
    end

endmodule

// File: tb/tb_board_line_clear.sv
module tb_board_line_clear;
    import tetris_board_pkg::*;

    localparam int NCELL = ROWS * COLS;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        busy, done;
    logic [4:0]  lines_cleared;
    logic        mem_grant;
    logic        mem_req, mem_we;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    board_line_clear dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .mem_grant     (mem_grant),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata)
    );

    always #5 clock = ~clock;

    logic [31:0] tb_mem   [NCELL];
    logic [31:0] init_mem [NCELL];
    logic [31:0] exp_mem  [NCELL];
    logic [31:0] rdata_q;
    logic        load_req = 1'b0;
    logic        clr_req  = 1'b0;
    bit          toggle_grant = 1'b0;
    int          rd_cnt, wr_cnt, oob_cnt, hold_bad, done_cnt;
    int          rd_log[$];
    int          exp_lines_q[$];
    int          exp_addr_q[$];
    logic        pend_valid = 1'b0;
    logic [11:0] pend_addr;
    logic        pend_we;
    logic [31:0] pend_wdata;
    int          tests = 0;
    int          failures = 0;

    assign mem_rdata = rdata_q;

    // RAM model with bus-protocol monitor; read data is garbage except the cycle after a granted read.
    always @(posedge clock) begin
        if (load_req) begin
            for (int i = 0; i < NCELL; i++) tb_mem[i] <= init_mem[i];
        end
        if (clr_req) begin
            rd_cnt <= 0; wr_cnt <= 0; oob_cnt <= 0; hold_bad <= 0; done_cnt <= 0;
            rd_log.delete();
        end else begin
            if (done) done_cnt <= done_cnt + 1;
            if (pend_valid && reset &&
                !(mem_req && mem_addr == pend_addr && mem_we == pend_we &&
                  (!pend_we || mem_wdata == pend_wdata)))
                hold_bad <= hold_bad + 1;
            if (mem_req && mem_grant) begin
                if (int'(mem_addr) >= NCELL) oob_cnt <= oob_cnt + 1;
                else if (mem_we) begin
                    tb_mem[mem_addr[7:0]] <= mem_wdata;
                    wr_cnt <= wr_cnt + 1;
                end else begin
                    rd_cnt <= rd_cnt + 1;
                    rd_log.push_back(int'(mem_addr));
                end
            end
        end
        if (mem_req && mem_grant && !mem_we && int'(mem_addr) < NCELL)
            rdata_q <= tb_mem[mem_addr[7:0]];
        else
            rdata_q <= $urandom;
        pend_valid <= reset && mem_req && !mem_grant;
        pend_addr  <= mem_addr;
        pend_we    <= mem_we;
        pend_wdata <= mem_wdata;
    end

    initial begin
        mem_grant = 1'b1;
        forever begin
            @(negedge clock);
            mem_grant = toggle_grant ? ~mem_grant : 1'b1;
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic clear_board();
        for (int i = 0; i < NCELL; i++) init_mem[i] = 32'h0;
    endtask

    // Reference: keep non-full rows in order, packed to the bottom.
    task automatic build_model(output int nfull);
        int k;
        bit full;
        nfull = 0;
        k = ROWS - 1;
        for (int i = 0; i < NCELL; i++) exp_mem[i] = 32'h0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            full = 1'b1;
            for (int c = 0; c < COLS; c++)
                if (init_mem[r*COLS+c][2:0] == 3'b000) full = 1'b0;
            if (full) nfull++;
            else begin
                for (int c = 0; c < COLS; c++) exp_mem[k*COLS+c] = init_mem[r*COLS+c];
                k--;
            end
        end
    endtask

    function automatic int first_mem_diff();
        for (int i = 0; i < NCELL; i++)
            if (tb_mem[i] !== exp_mem[i]) return i;
        return -1;
    endfunction

    // Load the board, start a pass and wait for done (done_at = cycle index, -1 on timeout).
    task automatic run_pass(input int budget, input bit extra_start, input bit start_at_done,
                            output int done_at);
        int n;
        int nfull;
        @(negedge clock);
        load_req = 1'b1; clr_req = 1'b1;
        @(negedge clock);
        load_req = 1'b0; clr_req = 1'b0;
        build_model(nfull);
        exp_lines_q.push_back(nfull);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 1;
        done_at = -1;
        while (n <= budget) begin
            if (done) begin
                done_at = n;
                break;
            end
            start = extra_start && (n == 10);
            @(negedge clock);
            n++;
        end
        start = start_at_done && (done_at > 0);
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0;
        repeat (3) @(negedge clock);
        tests++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", done); end
        tests++; if (lines_cleared !== 5'd0) begin failures++; $display("FAIL reset_lines got %0d want 0", lines_cleared); end
        tests++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_req got %b want 0", mem_req); end
        tests++; if (mem_we !== 1'b0) begin failures++; $display("FAIL reset_we got %b want 0", mem_we); end
        tests++; if (mem_addr !== 12'd0) begin failures++; $display("FAIL reset_addr got %0d want 0", mem_addr); end
        tests++; if (mem_wdata !== 32'd0) begin failures++; $display("FAIL reset_wdata got %h want 0", mem_wdata); end
        reset = 1'b1;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_empty();
        int done_at, exp, bad, got;
        clear_board();
        for (int r = ROWS - 1; r >= 0; r--) exp_addr_q.push_back(r * COLS);
        run_pass(200, 1'b0, 1'b0, done_at);
        exp = exp_lines_q.pop_front();
        tests++; if (done_at !== 41) begin failures++; $display("FAIL empty_done_cycle got %0d want 41", done_at); end
        tests++; if (lines_cleared !== 5'(exp)) begin failures++; $display("FAIL empty_lines got %0d want %0d", lines_cleared, exp); end
        tests++; if (rd_cnt !== 20) begin failures++; $display("FAIL empty_reads got %0d want 20", rd_cnt); end
        tests++; if (wr_cnt !== 0) begin failures++; $display("FAIL empty_writes got %0d want 0", wr_cnt); end
        bad = 0;
        while (exp_addr_q.size() > 0) begin
            exp = exp_addr_q.pop_front();
            got = (rd_log.size() > 0) ? rd_log.pop_front() : -1;
            if (got !== exp && bad == 0) begin
                bad = 1;
                $display("FAIL empty_read_addr got %0d want %0d", got, exp);
            end
        end
        tests++; if (bad) failures++;
        bad = first_mem_diff();
        tests++; if (bad !== -1) begin failures++; $display("FAIL empty_mem cell %0d got %h want %h", bad, tb_mem[bad], exp_mem[bad]); end
        tests++; if (done_cnt !== 1) begin failures++; $display("FAIL empty_done_pulses got %0d want 1", done_cnt); end
    endtask

    task automatic load_scenario2();
        clear_board();
        for (int c = 0; c < COLS; c++) init_mem[19*COLS+c] = 32'(COLOR_CYAN) | 32'h0100_0000;
        init_mem[18*COLS+0] = 32'(COLOR_PURPLE) | 32'hDEAD_0000;
    endtask

    task automatic check_pass(input string name, input int done_at);
        int exp, bad;
        exp = exp_lines_q.pop_front();
        tests++; if (done_at < 0) begin failures++; $display("FAIL %s_timeout got no done want done", name); end
        tests++; if (lines_cleared !== 5'(exp)) begin failures++; $display("FAIL %s_lines got %0d want %0d", name, lines_cleared, exp); end
        bad = first_mem_diff();
        tests++; if (bad !== -1) begin failures++; $display("FAIL %s_mem cell %0d got %h want %h", name, bad, tb_mem[bad], exp_mem[bad]); end
        tests++; if (done_cnt !== 1) begin failures++; $display("FAIL %s_done_pulses got %0d want 1", name, done_cnt); end
        tests++; if (hold_bad !== 0 || oob_cnt !== 0) begin failures++; $display("FAIL %s_bus got hold=%0d oob=%0d want 0/0", name, hold_bad, oob_cnt); end
        tests++; if (busy !== 1'b0) begin failures++; $display("FAIL %s_idle_busy got %b want 0", name, busy); end
    endtask

    task automatic test_single_line();
        int done_at;
        load_scenario2();
        run_pass(3000, 1'b0, 1'b0, done_at);
        check_pass("single", done_at);
        tests++; if (tb_mem[19*COLS] !== (32'(COLOR_PURPLE) | 32'hDEAD_0000)) begin
            failures++; $display("FAIL single_row19_col0 got %h want %h", tb_mem[19*COLS], 32'(COLOR_PURPLE) | 32'hDEAD_0000); end
    endtask

    task automatic test_four_lines();
        int done_at;
        clear_board();
        for (int r = 16; r < 20; r++)
            for (int c = 0; c < COLS; c++) init_mem[r*COLS+c] = 32'(((r + c) % 7) + 1) | (32'(r) << 8);
        for (int r = 12; r < 16; r++)
            for (int c = 0; c < COLS; c++)
                if (c % (r - 10) == 0) init_mem[r*COLS+c] = 32'((c % 7) + 1) | 32'hA500_0000 | (32'(r) << 16);
        run_pass(8000, 1'b0, 1'b0, done_at);
        check_pass("four", done_at);
    endtask

    task automatic test_nonadjacent();
        int done_at;
        clear_board();
        for (int c = 0; c < COLS; c++) begin
            init_mem[17*COLS+c] = 32'(COLOR_RED);
            init_mem[19*COLS+c] = 32'(COLOR_BLUE);
            if (c < 5) init_mem[18*COLS+c] = 32'(COLOR_GREEN) | (32'(c) << 20);
        end
        run_pass(8000, 1'b0, 1'b0, done_at);
        check_pass("nonadj", done_at);
    endtask

    task automatic test_full_board();
        int done_at;
        clear_board();
        for (int i = 0; i < NCELL; i++) init_mem[i] = 32'((i % 7) + 1);
        run_pass(20000, 1'b0, 1'b0, done_at);
        check_pass("full", done_at);
    endtask

    task automatic test_grant_toggle();
        int done_at;
        load_scenario2();
        toggle_grant = 1'b1;
        run_pass(6000, 1'b0, 1'b0, done_at);
        toggle_grant = 1'b0;
        check_pass("toggle", done_at);
    endtask

    task automatic test_back_to_back();
        int done_at;
        load_scenario2();
        run_pass(3000, 1'b1, 1'b1, done_at);
        check_pass("b2b", done_at);
    endtask

    task automatic test_reset_abort();
        int n, done_at;
        load_scenario2();
        @(negedge clock);
        load_req = 1'b1; clr_req = 1'b1;
        @(negedge clock);
        load_req = 1'b0; clr_req = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (n < 300 && mem_we !== 1'b1) begin
            @(negedge clock);
            n++;
        end
        tests++; if (mem_we !== 1'b1) begin failures++; $display("FAIL abort_reach_write got %b want 1", mem_we); end
        #2 reset = 1'b0;
        #1;
        tests++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got %b want 0", busy); end
        tests++; if (mem_req !== 1'b0) begin failures++; $display("FAIL abort_req got %b want 0", mem_req); end
        tests++; if (mem_we !== 1'b0) begin failures++; $display("FAIL abort_we got %b want 0", mem_we); end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        run_pass(3000, 1'b1, 1'b0, done_at);
        check_pass("after_abort", done_at);
    endtask

    initial begin
        start = 1'b0;
        reset = 1'b0;
        test_reset();
        test_empty();
        test_single_line();
        test_four_lines();
        test_nonadjacent();
        test_full_board();
        test_grant_toggle();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
